// File: rtl/kernel_cache_loader.sv
// kernel_cache_loader: fetches nine bytes into a shadow buffer and commits three 24-bit kernel words atomically
module kernel_cache_loader #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_valid,
    output logic [23:0]       cache0,
    output logic [23:0]       cache1,
    output logic [23:0]       cache2,
    output logic              busy,
    output logic              done,
    output logic              kernel_ready
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
    state_t            state;
    logic [ADDR_W-1:0] base;
    logic [3:0]        k;
    logic [7:0]        shadow [0:8];
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            base         <= '0;
            k            <= '0;
            for (int i = 0; i < 9; i++) shadow[i] <= '0;
            cache0       <= '0;
            cache1       <= '0;
            cache2       <= '0;
            mem_req      <= 1'b0;
            mem_addr     <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            kernel_ready <= 1'b0;
        end else begin
            mem_req <= 1'b0;
            done    <= 1'b0;
            case (state)
                IDLE: if (load_start) begin
                    base     <= base_addr;
                    k        <= '0;
                    mem_req  <= 1'b1;
                    mem_addr <= base_addr;
                    busy     <= 1'b1;
                    state    <= REQ;
                end
                REQ: state <= WAIT;
                WAIT: if (mem_valid) begin
                    shadow[k] <= mem_rdata;
                    // last byte bypasses the shadow so all three words land on one edge
                    if (k == 4'd8) begin
                        cache0       <= {shadow[0], shadow[1], shadow[2]};
                        cache1       <= {shadow[3], shadow[4], shadow[5]};
                        cache2       <= {shadow[6], shadow[7], mem_rdata};
                        done         <= 1'b1;
                        kernel_ready <= 1'b1;
                        state        <= DONE;
                    end else begin
                        k        <= k + 4'd1;
                        mem_req  <= 1'b1;
                        mem_addr <= base + ADDR_W'(k + 4'd1);
                        state    <= REQ;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_kernel_cache_loader.sv
// tb_kernel_cache_loader: random and directed loads checked cycle by cycle against a timeline model
module tb_kernel_cache_loader;
    logic        clk, rst, load_start, mem_req, mem_valid, busy, done, kernel_ready;
    logic [15:0] base_addr, mem_addr;
    logic [7:0]  mem_rdata;
    logic [23:0] cache0, cache1, cache2;

    kernel_cache_loader #(.ADDR_W(16)) dut (
        .clk(clk), .rst(rst), .load_start(load_start), .base_addr(base_addr),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_valid(mem_valid),
        .cache0(cache0), .cache1(cache1), .cache2(cache2),
        .busy(busy), .done(done), .kernel_ready(kernel_ready)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    logic [7:0]  mem [0:65535];
    int          waits [0:8];
    logic [15:0] drv_base;
    bit          junk;
    int          cyc = 0;

    // timeline model: a load started in cycle s requests byte k after all earlier bytes and their waits
    bit          m_act = 0;
    int          m_s, m_done;
    int          m_req [0:8];
    logic [15:0] m_base;
    logic [23:0] m_new [0:2];
    logic [23:0] e_cache [0:2] = '{24'h0, 24'h0, 24'h0};
    logic        e_req = 0, e_busy = 0, e_done = 0, e_ready = 0;
    logic [15:0] e_addr = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_act   = 0;
            e_cache = '{24'h0, 24'h0, 24'h0};
            e_ready = 0;
            e_addr  = 0;
        end else if (load_start && !e_busy) begin
            int acc;
            m_act  = 1;
            m_s    = cyc;
            m_base = base_addr;
            acc    = cyc + 1;
            for (int b = 0; b < 9; b++) begin
                m_req[b] = acc;
                acc += 2 + waits[b];
            end
            m_done = acc;
            for (int w = 0; w < 3; w++)
                m_new[w] = {mem[m_base + 16'(3*w)], mem[m_base + 16'(3*w+1)], mem[m_base + 16'(3*w+2)]};
        end
        cyc++;
        e_req = 0;
        for (int b = 0; b < 9; b++)
            if (m_act && cyc == m_req[b]) begin
                e_req  = 1;
                e_addr = m_base + 16'(b);
            end
        e_busy = m_act && cyc > m_s && cyc <= m_done;
        e_done = m_act && cyc == m_done;
        if (e_done) begin
            e_cache = m_new;
            e_ready = 1;
        end
    end

    // memory responder: answers each request after the wait count chosen for that byte
    initial begin
        bit          pend;
        int          cnt, idx;
        logic [15:0] paddr;
        pend = 0;
        mem_valid = 0;
        mem_rdata = 0;
        forever begin
            @(negedge clk);
            mem_valid = 0;
            mem_rdata = 8'($urandom);
            if (pend) begin
                if (cnt == 0) begin
                    mem_valid = 1;
                    mem_rdata = mem[paddr];
                    pend = 0;
                end else cnt--;
            end else if (junk && mem_req) begin
                mem_valid = 1;
                mem_rdata = 8'hFF;
            end
            if (mem_req) begin
                idx = int'(16'(mem_addr - drv_base));
                if (idx > 8) idx = 0;
                pend  = 1;
                paddr = mem_addr;
                cnt   = waits[idx];
            end
        end
    end

    int          n_chk = 0, n_fail = 0, done_at = -1, s;
    logic [15:0] addr_q [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
        chk("mem_req", 32'(mem_req), 32'(e_req));
        chk("mem_addr", 32'(mem_addr), 32'(e_addr));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("done", 32'(done), 32'(e_done));
        chk("kernel_ready", 32'(kernel_ready), 32'(e_ready));
        chk("cache0", 32'(cache0), 32'(e_cache[0]));
        chk("cache1", 32'(cache1), 32'(e_cache[1]));
        chk("cache2", 32'(cache2), 32'(e_cache[2]));
        if (mem_req === 1'b1) addr_q.push_back(mem_addr);
        if (done === 1'b1 && done_at < 0) done_at = cyc;
    endtask

    task automatic start(input logic [15:0] b, input int w);
        for (int i = 0; i < 9; i++) waits[i] = (w < 0) ? int'($urandom_range(0, 3)) : w;
        drv_base   = b;
        base_addr  = b;
        load_start = 1;
        s          = cyc;
        done_at    = -1;
        addr_q.delete();
        tick;
        load_start = 0;
        base_addr  = 16'($urandom);
    endtask

    task automatic run_load(input logic [15:0] b, input int w, input bit ign);
        start(b, w);
        for (int i = 0; i < 300; i++) begin
            tick;
            load_start = ign && (cyc == s + 5 || cyc == s + 19);
            if (load_start) base_addr = 16'h0300;
            if (done_at >= 0) break;
        end
        chk("done_seen", 32'(done_at >= 0), 32'd1);
        tick;
        load_start = 0;
    endtask

    initial begin
        rst = 1;
        load_start = 0;
        base_addr = 0;
        junk = 0;
        drv_base = 0;
        for (int i = 0; i < 9; i++) waits[i] = 0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        for (int i = 0; i < 9; i++) begin
            mem[16'h0100 + i] = 8'(i + 1);
            mem[16'h0200 + i] = 8'(8'hAA + i);
            mem[16'h0300 + i] = 8'(8'h30 + i);
            mem[16'(16'hFFFC + i)] = 8'(8'h50 + i);
        end
        tick;
        tick;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_cache0", 32'(cache0), 32'd0);
        rst = 0;
        tick;

        run_load(16'h0100, 0, 0);
        chk("zw_latency", 32'(done_at - s), 32'd19);
        chk("zw_cache0", 32'(cache0), 32'h010203);
        chk("zw_cache1", 32'(cache1), 32'h040506);
        chk("zw_cache2", 32'(cache2), 32'h070809);
        chk("zw_addr_first", 32'(addr_q[0]), 32'h0100);
        chk("zw_addr_last", 32'(addr_q[8]), 32'h0108);
        repeat (3) tick;

        run_load(16'h0100, 3, 0);
        chk("wait_latency", 32'(done_at - s), 32'd46);
        chk("wait_req_count", 32'(addr_q.size()), 32'd9);
        chk("wait_cache2", 32'(cache2), 32'h070809);

        start(16'h0200, 0);
        chk("dbuf_old_cache0", 32'(cache0), 32'h010203);
        chk("dbuf_ready_held", 32'(kernel_ready), 32'd1);
        for (int i = 0; i < 40 && done_at < 0; i++) tick;
        chk("dbuf_new_cache0", 32'(cache0), 32'hAAABAC);
        tick;

        junk = 1;
        run_load(16'h0100, 0, 1);
        junk = 0;
        repeat (3) tick;
        chk("ign_req_count", 32'(addr_q.size()), 32'd9);
        chk("ign_cache0", 32'(cache0), 32'h010203);
        chk("ign_busy", 32'(busy), 32'd0);

        run_load(16'hFFFC, 0, 0);
        chk("wrap_addr0", 32'(addr_q[0]), 32'hFFFC);
        chk("wrap_addr3", 32'(addr_q[3]), 32'hFFFF);
        chk("wrap_addr4", 32'(addr_q[4]), 32'h0000);
        chk("wrap_addr8", 32'(addr_q[8]), 32'h0004);
        chk("wrap_cache1", 32'(cache1), 32'h535455);

        start(16'h0100, 3);
        for (int i = 0; i < 60 && addr_q.size() < 5; i++) tick;
        chk("rst_reached_byte4", 32'(addr_q.size()), 32'd5);
        rst = 1;
        tick;
        rst = 0;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cache0", 32'(cache0), 32'd0);
        chk("rst_ready", 32'(kernel_ready), 32'd0);
        repeat (8) tick;
        run_load(16'h0200, 0, 0);
        chk("rst_reload_cache0", 32'(cache0), 32'hAAABAC);

        for (int n = 0; n < 8; n++) begin
            logic [15:0] b;
            b = 16'($urandom);
            for (int i = 0; i < 9; i++) mem[b + 16'(i)] = 8'($urandom);
            junk = 1'($urandom);
            run_load(b, -1, 1'($urandom));
            repeat ($urandom_range(0, 3)) tick;
        end
        junk = 0;
        repeat (4) tick;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
